// File: rtl/prio_enc_queue.sv
// Multi-request priority encoder: pending requests are queued in a bit register
// and issued one index per accepted beat, fixed-LSB or round-robin priority.
module prio_enc_queue #(
  parameter int N    = 8,
  parameter int W    = (N > 1) ? $clog2(N) : 1,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req_in,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [W-1:0] out_idx_q;
  logic [W-1:0] rr_ptr_q;

  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         sel_found;
  logic         load;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;
  int           scan_pos;

  assign sel_any = |pend_q;
  assign load    = (state_q == EMPTY) || out_ready;

  // Round-robin scan starts one past the last issued index and wraps modulo N,
  // so a non-power-of-two N never yields an out-of-range index.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    scan_pos  = 0;
    if (MODE == 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (pend_q[k]) sel_idx = W'(k);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_pos = (int'(rr_ptr_q) + k) % N;
        if (!sel_found && pend_q[scan_pos]) begin
          sel_idx   = W'(scan_pos);
          sel_found = 1'b1;
        end
      end
    end
  end

  // New requests are OR-ed in after the clear, so a re-request of the bit
  // being issued this cycle survives and is issued again later.
  always_comb begin
    clr_mask = '0;
    if (load && sel_any) clr_mask = N'(1) << sel_idx;
    set_mask = en ? req_in : '0;
    pend_d   = (pend_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      pend_q    <= '0;
      out_idx_q <= '0;
      rr_ptr_q  <= W'(N - 1);
    end else begin
      pend_q <= pend_d;
      if (load) begin
        if (sel_any) begin
          state_q   <= FULL;
          out_idx_q <= sel_idx;
          rr_ptr_q  <= sel_idx;
        end else begin
          state_q <= EMPTY;
        end
      end
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = (state_q == FULL);
  assign pending   = pend_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: a fixed-priority N=8 instance and a round-robin
// N=5 instance, with expected issue order queued per instance.
module tb_prio_enc_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       out_ready;

  logic       en_a;
  logic [7:0] req_a;
  logic [2:0] out_idx_a;
  logic       out_valid_a;
  logic [7:0] pending_a;

  logic       en_b;
  logic [4:0] req_b;
  logic [2:0] out_idx_b;
  logic       out_valid_b;
  logic [4:0] pending_b;

  int total = 0;
  int bad   = 0;
  int exp_a[$];
  int exp_b[$];

  always #5 clk = ~clk;

  prio_enc_queue #(.N(8), .MODE(0)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_a),
    .req_in   (req_a),
    .out_idx  (out_idx_a),
    .out_valid(out_valid_a),
    .out_ready(out_ready),
    .pending  (pending_a)
  );

  prio_enc_queue #(.N(5), .MODE(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_b),
    .req_in   (req_b),
    .out_idx  (out_idx_b),
    .out_valid(out_valid_b),
    .out_ready(out_ready),
    .pending  (pending_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A beat is accepted on the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_extra_beat", {29'b0, out_idx_a}, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_a.pop_front();
        $display("t=%0t a beat idx=%0d exp=%0d", $time, out_idx_a, e);
        chk("a_idx", {29'b0, out_idx_a}, e);
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (exp_b.size() == 0) begin
        chk("b_extra_beat", {29'b0, out_idx_b}, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_b.pop_front();
        $display("t=%0t b beat idx=%0d exp=%0d", $time, out_idx_b, e);
        chk("b_idx", {29'b0, out_idx_b}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    en_a = 1'b0; req_a = '0;
    en_b = 1'b0; req_b = '0;
    #2;
    chk("rst_pend_a", pending_a, 0);
    chk("rst_valid_a", out_valid_a, 0);
    chk("rst_idx_a", out_idx_a, 0);
    chk("rst_pend_b", pending_b, 0);
    chk("rst_valid_b", out_valid_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // single request bit 5
    en_a = 1'b1; req_a = 8'b0010_0000; exp_a.push_back(5);
    tick(1);
    en_a = 1'b0; req_a = '0;
    tick(4);
    chk("t1_pend", pending_a, 0);
    chk("t1_valid", out_valid_a, 0);
    chk("t1_q", exp_a.size(), 0);

    // three simultaneous requests issue lowest first
    en_a = 1'b1; req_a = 8'b1000_0101;
    exp_a.push_back(0); exp_a.push_back(2); exp_a.push_back(7);
    tick(1);
    en_a = 1'b0; req_a = '0;
    tick(6);
    chk("t2_valid", out_valid_a, 0);
    chk("t2_q", exp_a.size(), 0);

    // backpressure holds the output stable
    out_ready = 1'b0;
    en_a = 1'b1; req_a = 8'b0000_0110;
    tick(1);
    en_a = 1'b0; req_a = '0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_idx", out_idx_a, 1);
      chk("t3_hold_valid", out_valid_a, 1);
      chk("t3_hold_pend", pending_a, 8'h04);
      tick(1);
    end
    exp_a.push_back(1); exp_a.push_back(2);
    out_ready = 1'b1;
    tick(4);
    chk("t3_valid", out_valid_a, 0);
    chk("t3_q", exp_a.size(), 0);

    // re-request on the bit being loaded keeps it pending
    en_a = 1'b1; req_a = 8'b0000_1000;
    exp_a.push_back(3); exp_a.push_back(3);
    tick(2);
    chk("t5_pend", pending_a, 8'h08);
    chk("t5_idx", out_idx_a, 3);
    chk("t5_valid", out_valid_a, 1);
    en_a = 1'b0; req_a = '0;
    tick(4);
    chk("t5_pend_end", pending_a, 0);
    chk("t5_q", exp_a.size(), 0);

    // round-robin N=5, all requests held for 8 sampling edges
    for (int i = 0; i < 12; i++) exp_b.push_back(i % 5);
    en_b = 1'b1; req_b = 5'b11111;
    tick(8);
    en_b = 1'b0; req_b = '0;
    tick(8);
    chk("t4_valid", out_valid_b, 0);
    chk("t4_pend", pending_b, 0);
    chk("t4_q", exp_b.size(), 0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    en_a = 1'b1; req_a = 8'hF8;
    tick(1);
    en_a = 1'b0; req_a = '0;
    tick(1);
    chk("t6_pre_pend", pending_a, 8'hF0);
    chk("t6_pre_valid", out_valid_a, 1);
    chk("t6_pre_idx", out_idx_a, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pend", pending_a, 0);
    chk("t6_rst_valid", out_valid_a, 0);
    chk("t6_rst_idx", out_idx_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en_a = 1'b0; req_a = 8'hFF; out_ready = 1'b1;
    tick(5);
    chk("t6_post_valid", out_valid_a, 0);
    chk("t6_post_pend", pending_a, 0);
    req_a = '0;
    chk("end_q_a", exp_a.size(), 0);
    chk("end_q_b", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
